// File: rtl/ram_ctrl.sv
// rtl/ram_ctrl.sv - word RAM with wait states, byte-lane writes and a ready/busy handshake
// Optional feature macro: RAM_BOUNDS_CHECK_EN (reports out-of-range accesses on err)
module ram_ctrl #(
  parameter int BITS        = 32,
  parameter int RAMSIZE     = 512,
  parameter int ADDR        = $clog2(RAMSIZE),
  parameter int WAIT_STATES = 1
) (
  input  logic              clk,
  input  logic              clr,
  input  logic [BITS-1:0]   dataIn,
  input  logic              read,
  input  logic              write,
  input  logic [ADDR-1:0]   address,
  input  logic [BITS/8-1:0] byteEn,
  output logic [BITS-1:0]   dataOut,
  output logic              ready,
  output logic              busy,
  output logic              err
);

  localparam int LANES = BITS / 8;

  // RAMSIZE always fits in ADDR+1 bits; when RAMSIZE is a power of two the
  // compare below folds to constant true and disappears.
  localparam logic [ADDR:0] LIMIT = (ADDR + 1)'(RAMSIZE);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              op_wr_q, op_wr_d;
  logic [ADDR-1:0]   addr_q, addr_d;
  logic [BITS-1:0]   data_q, data_d;
  logic [LANES-1:0]  be_q, be_d;
  logic [BITS-1:0]   dout_q, dout_d;

  logic              accept;
  logic              access;
  logic              in_range;
  logic              mem_we;
  logic [BITS-1:0]   rd_word;

  // Backing storage: deliberately never reset, contents survive clr
  logic [BITS-1:0]   mem [RAMSIZE];

  assign in_range = ({1'b0, addr_q} < LIMIT);

  // State and latched-request registers; clr wins over any acceptance or access
  always_ff @(posedge clk) begin
    if (clr) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      op_wr_q <= 1'b0;
      addr_q  <= '0;
      data_q  <= '0;
      be_q    <= '0;
      dout_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      op_wr_q <= op_wr_d;
      addr_q  <= addr_d;
      data_q  <= data_d;
      be_q    <= be_d;
      dout_q  <= dout_d;
    end
  end

  // Next-state: accept in IDLE, count down in WAIT, DONE lasts one cycle
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    access  = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (read || write) begin
          accept  = 1'b1;
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) begin
          access  = 1'b1;
          state_d = S_DONE;
        end
      end
      S_DONE: state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request latch, wait counter and read-data capture
  always_comb begin
    cnt_d   = cnt_q;
    op_wr_d = op_wr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    be_d    = be_q;
    dout_d  = dout_q;
    rd_word = in_range ? mem[addr_q] : '0;
    if (accept) begin
      op_wr_d = write;          // write wins when read and write collide
      addr_d  = address;
      data_d  = dataIn;
      be_d    = byteEn;
      cnt_d   = 4'(WAIT_STATES);
    end else if (state_q == S_WAIT && cnt_q != 4'd0) begin
      cnt_d = cnt_q - 4'd1;
    end
    if (access && !op_wr_q) begin
      dout_d = rd_word;
    end
  end

  // A write commits on the edge entering DONE unless clr aborts it
  assign mem_we = access && op_wr_q && in_range && !clr;

  // Per-lane memory write
  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < LANES; i++) begin
        if (be_q[i]) begin
          mem[addr_q][8*i +: 8] <= data_q[8*i +: 8];
        end
      end
    end
  end

`ifdef RAM_BOUNDS_CHECK_EN
  logic err_q, err_d;

  // Out-of-range flag: set with the access, cleared when DONE is left
  always_comb begin
    err_d = err_q;
    if (access) begin
      err_d = !in_range;
    end else if (state_q == S_DONE) begin
      err_d = 1'b0;
    end
  end

  // Flag register
  always_ff @(posedge clk) begin
    if (clr) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign err = err_q;
`else
  assign err = 1'b0;
`endif

  // Handshake outputs decoded from the state register
  always_comb begin
    ready   = (state_q == S_DONE);
    busy    = (state_q != S_IDLE);
    dataOut = dout_q;
  end

endmodule

// File: tb/tb_ram_ctrl.sv
// tb/tb_ram_ctrl.sv - self-checking scoreboard bench for ram_ctrl
module tb_ram_ctrl;

`ifdef RAM_BOUNDS_CHECK_EN
  localparam logic EXP_ERR = 1'b1;
`else
  localparam logic EXP_ERR = 1'b0;
`endif

  logic        clk;
  logic        clr [4];
  logic        rd  [4];
  logic        wr  [4];
  logic [31:0] din [4];
  logic [8:0]  adr [4];
  logic [3:0]  be  [4];
  logic [31:0] dout[4];
  logic        rdy [4];
  logic        bsy [4];
  logic        er  [4];

  int checks   = 0;
  int failures = 0;
  logic [31:0] exp_q[$];

  // Instance 0: WS=1, 1: WS=0, 2: WS=7, 3: WS=3; all RAMSIZE=500
  for (genvar g = 0; g < 4; g++) begin : g_dut
    ram_ctrl #(
      .BITS(32), .RAMSIZE(500),
      .WAIT_STATES(g == 0 ? 1 : g == 1 ? 0 : g == 2 ? 7 : 3)
    ) u_dut (
      .clk(clk), .clr(clr[g]), .dataIn(din[g]), .read(rd[g]), .write(wr[g]),
      .address(adr[g]), .byteEn(be[g]), .dataOut(dout[g]), .ready(rdy[g]),
      .busy(bsy[g]), .err(er[g])
    );
  end

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic access(input int k, input bit w, input bit r, input logic [8:0] a,
                        input logic [31:0] d, input logic [3:0] b,
                        output int lat, output int busy_cyc, output logic [31:0] q,
                        output logic e, output bit seen);
    @(negedge clk);
    wr[k] = w; rd[k] = r; adr[k] = a; din[k] = d; be[k] = b;
    @(posedge clk);
    lat = 0; busy_cyc = 0; seen = 0; q = '0; e = 1'b0;
    @(negedge clk);
    wr[k] = 1'b0; rd[k] = 1'b0;
    while (!seen && lat < 40) begin
      if (rdy[k]) begin
        seen = 1; q = dout[k]; e = er[k];
      end else begin
        if (bsy[k]) busy_cyc++;
        lat++;
        @(negedge clk);
      end
    end
  endtask

  task automatic test_reset();
    for (int k = 0; k < 4; k++) begin
      clr[k] = 1'b1; rd[k] = 1'b0; wr[k] = 1'b0; din[k] = '0; adr[k] = '0; be[k] = '0;
    end
    repeat (2) @(posedge clk);
    @(negedge clk);
    for (int k = 0; k < 4; k++) begin
      clr[k] = 1'b0;
      checks++; if (dout[k] !== 32'h0) begin failures++; $display("FAIL reset_dout[%0d]: got %h want 0", k, dout[k]); end
      checks++; if (rdy[k] !== 1'b0) begin failures++; $display("FAIL reset_ready[%0d]: got %b want 0", k, rdy[k]); end
      checks++; if (bsy[k] !== 1'b0) begin failures++; $display("FAIL reset_busy[%0d]: got %b want 0", k, bsy[k]); end
      checks++; if (er[k] !== 1'b0) begin failures++; $display("FAIL reset_err[%0d]: got %b want 0", k, er[k]); end
    end
  endtask

  task automatic test_write_read();
    int lat, bc; logic [31:0] q, ex; logic e; bit seen;
    access(0, 1, 0, 9'h3, 32'h5, 4'hF, lat, bc, q, e, seen);
    checks++; if (!seen || lat != 2) begin failures++; $display("FAIL wr_latency: got %0d want 2 (seen=%0d)", lat, seen); end
    checks++; if (q !== 32'h0) begin failures++; $display("FAIL wr_keeps_dout: got %h want 0", q); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL wr_err: got %b want 0", e); end
    exp_q.push_back(32'h0000_0005);
    access(0, 0, 1, 9'h3, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (!seen || lat != 2) begin failures++; $display("FAIL rd_latency: got %0d want 2 (seen=%0d)", lat, seen); end
    checks++; if (q !== ex) begin failures++; $display("FAIL rd_data: got %h want %h", q, ex); end
    checks++; if (e !== 1'b0) begin failures++; $display("FAIL rd_err: got %b want 0", e); end
  endtask

  task automatic test_byte_lanes();
    int lat, bc; logic [31:0] q, ex, full, part; logic [3:0] b; logic [8:0] a; logic e; bit seen;
    access(0, 1, 0, 9'h10, 32'hAABBCCDD, 4'hF, lat, bc, q, e, seen);
    access(0, 1, 0, 9'h10, 32'h11223344, 4'h5, lat, bc, q, e, seen);
    exp_q.push_back(32'hAA22CC44);
    access(0, 0, 1, 9'h10, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (!seen || q !== ex) begin failures++; $display("FAIL lanes_fixed: got %h want %h", q, ex); end
    for (int i = 0; i < 6; i++) begin
      a = 9'(9'h40 + i * 3);
      full = $urandom; part = $urandom;
      b = (i == 0) ? 4'h0 : 4'($urandom_range(1, 15));
      access(0, 1, 0, a, full, 4'hF, lat, bc, q, e, seen);
      access(0, 1, 0, a, part, b, lat, bc, q, e, seen);
      ex = full;
      for (int j = 0; j < 4; j++) if (b[j]) ex[8*j +: 8] = part[8*j +: 8];
      exp_q.push_back(ex);
      access(0, 0, 1, a, 32'h0, 4'h0, lat, bc, q, e, seen);
      ex = exp_q.pop_front();
      checks++; if (!seen || q !== ex) begin failures++; $display("FAIL lanes_rand[%0d] be=%h: got %h want %h", i, b, q, ex); end
    end
  endtask

  task automatic test_wait_sweep();
    int lat, bc, ws; logic [31:0] q, ex; logic e; bit seen;
    for (int k = 1; k <= 2; k++) begin
      ws = (k == 1) ? 0 : 7;
      access(k, 1, 0, 9'h30, 32'hC0DE_0000 + k, 4'hF, lat, bc, q, e, seen);
      checks++; if (!seen || lat != ws + 1) begin failures++; $display("FAIL sweep_wr_lat ws=%0d: got %0d want %0d", ws, lat, ws + 1); end
      checks++; if (bc != ws + 1) begin failures++; $display("FAIL sweep_busy ws=%0d: got %0d want %0d", ws, bc, ws + 1); end
      exp_q.push_back(32'hC0DE_0000 + k);
      access(k, 0, 1, 9'h30, 32'h0, 4'h0, lat, bc, q, e, seen);
      ex = exp_q.pop_front();
      checks++; if (!seen || lat != ws + 1) begin failures++; $display("FAIL sweep_rd_lat ws=%0d: got %0d want %0d", ws, lat, ws + 1); end
      checks++; if (q !== ex) begin failures++; $display("FAIL sweep_data ws=%0d: got %h want %h", ws, q, ex); end
    end
  endtask

  task automatic test_collision_hold();
    int lat, bc, n; logic [31:0] q, ex; logic e; bit seen;
    access(0, 1, 0, 9'h21, 32'h55, 4'hF, lat, bc, q, e, seen);
    exp_q.push_back(32'h55);
    access(0, 0, 1, 9'h21, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex) begin failures++; $display("FAIL coll_pre: got %h want %h", q, ex); end
    @(negedge clk);
    rd[0] = 1'b1; wr[0] = 1'b1; adr[0] = 9'h20; din[0] = 32'h1234; be[0] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    adr[0] = 9'h21; din[0] = 32'hFFFF; be[0] = 4'h0;
    n = 0;
    while (!rdy[0] && n < 20) begin @(negedge clk); n++; end
    checks++; if (!rdy[0] || n != 2) begin failures++; $display("FAIL coll_ready: got %0d want 2", n); end
    checks++; if (dout[0] !== 32'h55) begin failures++; $display("FAIL coll_dout_hold: got %h want 55", dout[0]); end
    @(negedge clk);
    checks++; if (bsy[0] !== 1'b0 || rdy[0] !== 1'b0) begin failures++; $display("FAIL coll_idle_gap: got busy=%b ready=%b want 0 0", bsy[0], rdy[0]); end
    @(negedge clk);
    checks++; if (bsy[0] !== 1'b1) begin failures++; $display("FAIL coll_reaccept: got %b want 1", bsy[0]); end
    rd[0] = 1'b0; wr[0] = 1'b0;
    n = 0;
    while (!rdy[0] && n < 20) begin @(negedge clk); n++; end
    checks++; if (!rdy[0]) begin failures++; $display("FAIL coll_second_ready: got 0 want 1"); end
    exp_q.push_back(32'h1234);
    access(0, 0, 1, 9'h20, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex) begin failures++; $display("FAIL coll_write_won: got %h want %h", q, ex); end
    exp_q.push_back(32'h55);
    access(0, 0, 1, 9'h21, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex) begin failures++; $display("FAIL coll_be0_nochange: got %h want %h", q, ex); end
  endtask

  task automatic test_reset_mid_op();
    int lat, bc; logic [31:0] q, ex; logic e; bit seen, hit;
    access(3, 1, 0, 9'h8, 32'h1, 4'hF, lat, bc, q, e, seen);
    @(negedge clk);
    wr[3] = 1'b1; adr[3] = 9'h8; din[3] = 32'hDEAD; be[3] = 4'hF;
    @(posedge clk);
    @(negedge clk);
    wr[3] = 1'b0;
    @(posedge clk);
    @(negedge clk);
    clr[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[3] = 1'b0;
    checks++; if (bsy[3] !== 1'b0) begin failures++; $display("FAIL midclr_busy: got %b want 0", bsy[3]); end
    hit = 0;
    repeat (8) begin @(negedge clk); if (rdy[3]) hit = 1; end
    checks++; if (hit) begin failures++; $display("FAIL midclr_no_ready: got 1 want 0"); end
    exp_q.push_back(32'h1);
    access(3, 0, 1, 9'h8, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex) begin failures++; $display("FAIL midclr_old_data: got %h want %h", q, ex); end
  endtask

  task automatic test_clr_in_done();
    int lat, bc; logic [31:0] q, ex; logic e; bit seen;
    access(3, 1, 0, 9'h9, 32'h77, 4'hF, lat, bc, q, e, seen);
    clr[3] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    clr[3] = 1'b0;
    checks++; if (dout[3] !== 32'h0 || rdy[3] !== 1'b0 || bsy[3] !== 1'b0) begin
      failures++; $display("FAIL doneclr_outputs: got dout=%h ready=%b busy=%b want 0 0 0", dout[3], rdy[3], bsy[3]);
    end
    exp_q.push_back(32'h77);
    access(3, 0, 1, 9'h9, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex) begin failures++; $display("FAIL doneclr_committed: got %h want %h", q, ex); end
  endtask

  task automatic test_bounds();
    int lat, bc; logic [31:0] q, ex; logic e; bit seen;
    access(0, 1, 0, 9'd499, 32'h1234_5678, 4'hF, lat, bc, q, e, seen);
    exp_q.push_back(32'h1234_5678);
    access(0, 0, 1, 9'd499, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (q !== ex || e !== 1'b0) begin failures++; $display("FAIL bounds_last_word: got %h err=%b want %h err=0", q, e, ex); end
    access(0, 1, 0, 9'd500, 32'hCAFE, 4'hF, lat, bc, q, e, seen);
    checks++; if (!seen || e !== EXP_ERR) begin failures++; $display("FAIL bounds_wr_err: got %b want %b", e, EXP_ERR); end
    checks++; if (q !== ex) begin failures++; $display("FAIL bounds_wr_dout_hold: got %h want %h", q, ex); end
    @(negedge clk);
    checks++; if (er[0] !== 1'b0) begin failures++; $display("FAIL bounds_err_clear: got %b want 0", er[0]); end
    exp_q.push_back(32'h0);
    access(0, 0, 1, 9'd500, 32'h0, 4'h0, lat, bc, q, e, seen);
    ex = exp_q.pop_front();
    checks++; if (!seen || q !== ex) begin failures++; $display("FAIL bounds_rd_data: got %h want %h", q, ex); end
    checks++; if (e !== EXP_ERR) begin failures++; $display("FAIL bounds_rd_err: got %b want %b", e, EXP_ERR); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_byte_lanes();
    test_wait_sweep();
    test_collision_hold();
    test_reset_mid_op();
    test_clr_in_done();
    test_bounds();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
